flt_mc: RTL and testbench

Multi-channel, time-multiplexed FIR filter. It is the parametrised successor of the single-channel FLT block and uses the same coefficient-write port style. The block holds one coefficient set shared by all channels and a separate delay line for each channel. It accepts one tagged sample at a time over a valid/ready handshake, evaluates the filter with one multiply-accumulate per cycle, and returns a rounded, saturated result with its channel tag. It sits between the sample front end and downstream processing and replaces the fixed single-stream filter.

---
 rtl/flt_mc.sv | 218 +++++++++++++++++++++
 tb/tb_flt_mc.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flt_mc.sv
// Multi-channel time-multiplexed FIR: one shared coefficient set, one delay line per channel,
// one multiply-accumulate per cycle, rounded and saturated result with its channel tag.
module flt_mc #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned MEM_WIDTH  = 32,
    parameter int unsigned IN_WIDTH   = 24,
    parameter int unsigned OUT_WIDTH  = 24,
    parameter int unsigned COF_WIDTH  = 16,
    parameter int unsigned N_TAPS     = 8,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CH_WIDTH   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
    input  logic                  In_Valid_SI,
    output logic                  In_Ready_SO,
    input  logic [CH_WIDTH-1:0]   In_Ch_DI,
    input  logic [IN_WIDTH-1:0]   FLT_In_DI,
    output logic                  Out_Valid_SO,
    input  logic                  Out_Ready_SI,
    output logic [CH_WIDTH-1:0]   Out_Ch_DO,
    output logic [OUT_WIDTH-1:0]  FLT_Out_DO,
    output logic                  Sat_SO,
    output logic                  WrErr_SO
);

    localparam int unsigned TapW  = $clog2(N_TAPS);
    localparam int unsigned ProdW = IN_WIDTH + COF_WIDTH;
    localparam int unsigned AccW  = ProdW + TapW;
    localparam int unsigned RndW  = AccW + 1;

    localparam logic signed [RndW-1:0] RndHalf =
        {{(RndW - COF_WIDTH + 1){1'b0}}, 1'b1, {(COF_WIDTH - 2){1'b0}}};
    localparam logic signed [RndW-1:0] OutMax =
        {{(RndW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [RndW-1:0] OutMin =
        {{(RndW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StShift, StMac, StOut} state_e;

    state_e state_q, state_d;

    logic signed [COF_WIDTH-1:0] coef_q [N_TAPS];
    logic signed [COF_WIDTH-1:0] coef_d [N_TAPS];
    logic signed [IN_WIDTH-1:0]  dl_q   [N_CH][N_TAPS];
    logic signed [IN_WIDTH-1:0]  dl_d   [N_CH][N_TAPS];

    logic                        bypass_q, bypass_d;
    logic                        ready_q;
    logic signed [IN_WIDTH-1:0]  smp_q, smp_d;
    logic [CH_WIDTH-1:0]         ch_q, ch_d;
    logic signed [AccW-1:0]      acc_q, acc_d;
    logic [TapW-1:0]             k_q, k_d;
    logic                        out_vld_q, out_vld_d;
    logic [OUT_WIDTH-1:0]        out_q, out_d;
    logic [CH_WIDTH-1:0]         out_ch_q, out_ch_d;
    logic                        sat_q, sat_d;
    logic                        wrerr_q, wrerr_d;

    logic                        in_rdy;
    logic                        hit_coef, hit_ctrl;
    logic signed [ProdW-1:0]     prod;
    logic signed [RndW-1:0]      rnd_sum, rnd;
    logic                        unused_par_hi;

    assign unused_par_hi = ^PAR_In_DI[MEM_WIDTH-1:COF_WIDTH];

    // Returns {saturated, clamped value}.
    function automatic logic [OUT_WIDTH:0] sat_fn(input logic signed [RndW-1:0] v);
        logic [OUT_WIDTH:0] res;
        res = {1'b0, v[OUT_WIDTH-1:0]};
        if (v > OutMax) begin
            res = {1'b1, OutMax[OUT_WIDTH-1:0]};
        end else if (v < OutMin) begin
            res = {1'b1, OutMin[OUT_WIDTH-1:0]};
        end
        return res;
    endfunction

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (In_Valid_SI && in_rdy) state_d = StShift;
            StShift: state_d = StMac;
            StMac:   if (k_q == TapW'(N_TAPS - 1)) state_d = StOut;
            StOut:   if (out_vld_q && Out_Ready_SI) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_rdy       = ready_q && (state_q == StIdle);
        In_Ready_SO  = in_rdy;
        Out_Valid_SO = out_vld_q;
        Out_Ch_DO    = out_ch_q;
        FLT_Out_DO   = out_q;
        Sat_SO       = sat_q;
        WrErr_SO     = wrerr_q;
    end

    assign hit_coef = Addr_DI < ADDR_WIDTH'(N_TAPS);
    assign hit_ctrl = Addr_DI == ADDR_WIDTH'(N_TAPS);
    assign prod     = ProdW'(dl_q[ch_q][k_q]) * ProdW'(coef_q[k_q]);
    assign rnd_sum  = RndW'(acc_q) + RndHalf;
    assign rnd      = rnd_sum >>> (COF_WIDTH - 1);

    always_comb begin
        coef_d    = coef_q;
        dl_d      = dl_q;
        bypass_d  = bypass_q;
        smp_d     = smp_q;
        ch_d      = ch_q;
        acc_d     = acc_q;
        k_d       = k_q;
        out_vld_d = out_vld_q;
        out_d     = out_q;
        out_ch_d  = out_ch_q;
        sat_d     = sat_q;
        wrerr_d   = WrEn_SI && (state_q != StIdle) && (hit_coef || hit_ctrl);

        // Writes land before the shift, so a same-cycle accept sees the new state.
        if (WrEn_SI && (state_q == StIdle)) begin
            if (hit_coef) begin
                coef_d[TapW'(Addr_DI)] = PAR_In_DI[COF_WIDTH-1:0];
            end else if (hit_ctrl) begin
                if (PAR_In_DI[1]) begin
                    for (int c = 0; c < N_CH; c++) begin
                        for (int t = 0; t < N_TAPS; t++) begin
                            dl_d[c][t] = '0;
                        end
                    end
                end else begin
                    bypass_d = PAR_In_DI[0];
                end
            end
        end

        case (state_q)
            StIdle: begin
                if (In_Valid_SI && in_rdy) begin
                    smp_d = FLT_In_DI;
                    ch_d  = In_Ch_DI;
                end
            end
            StShift: begin
                for (int t = N_TAPS - 1; t > 0; t--) begin
                    dl_d[ch_q][t] = dl_q[ch_q][t-1];
                end
                dl_d[ch_q][0] = smp_q;
                acc_d         = '0;
                k_d           = '0;
            end
            StMac: begin
                acc_d = acc_q + AccW'(prod);
                k_d   = k_q + 1'b1;
            end
            StOut: begin
                // First OUT cycle registers the rounded result; valid rises one cycle later.
                if (!out_vld_q) begin
                    out_vld_d = 1'b1;
                    out_ch_d  = ch_q;
                    if (bypass_q) begin
                        {sat_d, out_d} = sat_fn(RndW'(smp_q));
                    end else begin
                        {sat_d, out_d} = sat_fn(rnd);
                    end
                end else if (Out_Ready_SI) begin
                    out_vld_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            coef_q    <= '{default: '0};
            dl_q      <= '{default: '{default: '0}};
            bypass_q  <= 1'b0;
            ready_q   <= 1'b0;
            smp_q     <= '0;
            ch_q      <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            out_ch_q  <= '0;
            sat_q     <= 1'b0;
            wrerr_q   <= 1'b0;
        end else begin
            coef_q    <= coef_d;
            dl_q      <= dl_d;
            bypass_q  <= bypass_d;
            ready_q   <= 1'b1;
            smp_q     <= smp_d;
            ch_q      <= ch_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            out_ch_q  <= out_ch_d;
            sat_q     <= sat_d;
            wrerr_q   <= wrerr_d;
        end
    end

endmodule

// File: tb/tb_flt_mc.sv
// Self-checking bench for flt_mc: hand-derived vector table, corner-case sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_flt_mc;

    localparam int ADDR_W = 5;
    localparam int MEM_W  = 32;
    localparam int IN_W   = 24;
    localparam int OUT_W  = 24;
    localparam int COF_W  = 16;
    localparam int NT     = 8;
    localparam int NC     = 4;
    localparam int CH_W   = 2;
    localparam longint OMAX = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint OMIN = -(longint'(1) <<< (OUT_W - 1));

    logic              clk, rst, wr_en, in_valid, in_ready, out_valid, out_ready, sat, wr_err;
    logic [ADDR_W-1:0] addr;
    logic [MEM_W-1:0]  par;
    logic [CH_W-1:0]   in_ch, out_ch;
    logic [IN_W-1:0]   flt_in;
    logic [OUT_W-1:0]  flt_out;

    flt_mc dut (
        .Clk_CI      (clk),
        .Rst_RI      (rst),
        .WrEn_SI     (wr_en),
        .Addr_DI     (addr),
        .PAR_In_DI   (par),
        .In_Valid_SI (in_valid),
        .In_Ready_SO (in_ready),
        .In_Ch_DI    (in_ch),
        .FLT_In_DI   (flt_in),
        .Out_Valid_SO(out_valid),
        .Out_Ready_SI(out_ready),
        .Out_Ch_DO   (out_ch),
        .FLT_Out_DO  (flt_out),
        .Sat_SO      (sat),
        .WrErr_SO    (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;

    // Reference model state.
    longint coef_m [NT];
    longint dl_m   [NC][NT];
    bit     byp_m;

    typedef struct {
        int     setup;
        int     ch;
        int     x;
        longint exp;
        bit     sat;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        byp_m = 1'b0;
        for (int i = 0; i < NT; i++) coef_m[i] = 0;
        for (int c = 0; c < NC; c++) for (int i = 0; i < NT; i++) dl_m[c][i] = 0;
    endfunction

    function automatic void model_write(input int a, input logic [MEM_W-1:0] d);
        logic signed [COF_W-1:0] cv;
        cv = d[COF_W-1:0];
        if (a < NT) begin
            coef_m[a] = longint'(cv);
        end else if (a == NT) begin
            if (d[1]) begin
                for (int c = 0; c < NC; c++) for (int i = 0; i < NT; i++) dl_m[c][i] = 0;
            end else begin
                byp_m = d[0];
            end
        end
    endfunction

    function automatic void model_sample(input int ch, input int x, output longint r,
                                         output bit s);
        longint acc, num, den;
        for (int i = NT - 1; i > 0; i--) dl_m[ch][i] = dl_m[ch][i-1];
        dl_m[ch][0] = x;
        if (byp_m) begin
            r = x;
        end else begin
            acc = 0;
            for (int i = 0; i < NT; i++) acc += dl_m[ch][i] * coef_m[i];
            den = longint'(1) <<< (COF_W - 1);
            num = acc + den / 2;
            r = num / den;
            if ((num % den) != 0 && num < 0) r = r - 1;
        end
        s = 1'b0;
        if (r > OMAX) begin r = OMAX; s = 1'b1; end
        if (r < OMIN) begin r = OMIN; s = 1'b1; end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [MEM_W-1:0] d);
        wr_en = 1'b1;
        addr  = ADDR_W'(a);
        par   = d;
        tick();
        wr_en = 1'b0;
        model_write(a, d);
    endtask

    task automatic setup(input int code);
        case (code)
            1: for (int i = 0; i < NT; i++) wr(i, 32'h4000);
            2: begin
                wr(NT, 32'h2);
                wr(0, 32'h1);
                for (int i = 1; i < NT; i++) wr(i, 32'h0);
            end
            3: begin
                wr(NT, 32'h2);
                for (int i = 0; i < NT; i++) wr(i, 32'h7FFF);
            end
            4: wr(NT, 32'h1);
            5: begin
                wr(NT, 32'h0);
                for (int i = 0; i < NT; i++) wr(i, 32'h4000);
            end
            default: ;
        endcase
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        chk({name, " in_ready"}, longint'(in_ready), 1);
    endtask

    // One full transaction; optional same-cycle write and an Out_Ready stall.
    task automatic xfer(input int ch, input int x, input longint exp, input bit esat,
                        input string name, input int stall, input bit cw, input int wa,
                        input logic [MEM_W-1:0] wd);
        int n;
        wait_ready(name);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        in_ch     = CH_W'(ch);
        flt_in    = IN_W'(x);
        wr_en     = cw;
        addr      = ADDR_W'(wa);
        par       = wd;
        tick();
        in_valid  = 1'b0;
        wr_en     = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        chk({name, " latency"}, n, NT + 2);
        if (stall > 0) begin
            repeat (stall) tick();
            chk({name, " stall valid"}, longint'(out_valid), 1);
            chk({name, " stall in_ready"}, longint'(in_ready), 0);
            out_ready = 1'b1;
        end
        chk({name, " data"}, longint'($signed(flt_out)), exp);
        chk({name, " sat"}, longint'(sat), longint'(esat));
        chk({name, " ch"}, longint'(out_ch), ch);
        tick();
        chk({name, " valid drop"}, longint'(out_valid), 0);
        chk({name, " back-to-back ready"}, longint'(in_ready), 1);
    endtask

    initial begin
        longint mr;
        bit     ms;
        int     n;

        rst = 1'b1; wr_en = 1'b0; addr = '0; par = '0; in_valid = 1'b0; in_ch = '0;
        flt_in = '0; out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", longint'(in_ready), 0);
        chk("rst out_valid", longint'(out_valid), 0);
        chk("rst flt_out", longint'(flt_out), 0);
        chk("rst sat", longint'(sat), 0);
        chk("rst wr_err", longint'(wr_err), 0);
        rst = 1'b0;
        #1;
        chk("release in_ready before edge", longint'(in_ready), 0);
        tick();
        chk("release in_ready after edge", longint'(in_ready), 1);

        // Impulse on ch0 interleaved with a step on ch1, then rounding/saturation/bypass.
        for (int i = 0; i < 9; i++) begin
            tbl.push_back('{(i == 0) ? 1 : 0, 0, (i == 0) ? 1000 : 0, (i < 8) ? 500 : 0, 1'b0});
            tbl.push_back('{0, 1, 200, 100 * ((i < 8) ? i + 1 : 8), 1'b0});
        end
        tbl.push_back('{2, 0, 16384, 1, 1'b0});
        tbl.push_back('{0, 0, -16384, 0, 1'b0});
        tbl.push_back('{0, 0, 16383, 0, 1'b0});
        tbl.push_back('{0, 0, -16385, -1, 1'b0});
        tbl.push_back('{3, 2, 8388607, 8388351, 1'b0});
        tbl.push_back('{0, 2, 8388607, 8388607, 1'b1});
        tbl.push_back('{0, 2, 8388607, 8388607, 1'b1});
        tbl.push_back('{4, 3, -5, -5, 1'b0});
        tbl.push_back('{0, 3, -8388608, -8388608, 1'b0});
        tbl.push_back('{5, 3, 0, -4194306, 1'b0});

        foreach (tbl[i]) begin
            if (tbl[i].setup != 0) setup(tbl[i].setup);
            if (i == 0) chk("idle write no wr_err", longint'(wr_err), 0);
            model_sample(tbl[i].ch, tbl[i].x, mr, ms);
            xfer(tbl[i].ch, tbl[i].x, tbl[i].exp, tbl[i].sat, $sformatf("tbl%0d", i), 0, 1'b0,
                 0, '0);
        end

        // Writes during MAC are dropped and flagged; unmapped addresses stay silent.
        model_sample(0, 1000, mr, ms);
        wait_ready("macwr");
        in_valid = 1'b1; in_ch = '0; flt_in = IN_W'(1000);
        tick();
        in_valid = 1'b0;
        tick();
        wr_en = 1'b1; addr = '0; par = 32'h7FFF;
        tick();
        chk("macwr wr_err pulse", longint'(wr_err), 1);
        addr = ADDR_W'(20);
        tick();
        wr_en = 1'b0;
        chk("macwr wr_err one cycle / unmapped", longint'(wr_err), 0);
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        chk("macwr data", longint'($signed(flt_out)), mr);
        tick();
        model_sample(1, 300, mr, ms);
        xfer(1, 300, mr, ms, "coef unchanged", 0, 1'b0, 0, '0);

        model_sample(2, 12345, mr, ms);
        xfer(2, 12345, mr, ms, "stall", 5, 1'b0, 0, '0);

        model_write(0, 32'h2000);
        model_sample(1, 777, mr, ms);
        xfer(1, 777, mr, ms, "write+accept", 0, 1'b1, 0, 32'h2000);
        model_write(NT, 32'h2);
        model_sample(1, 4000, mr, ms);
        xfer(1, 4000, mr, ms, "clr+accept", 0, 1'b1, NT, 32'h2);

        for (int it = 0; it < 40; it++) begin
            int ch, x, wa, st;
            bit cw;
            logic [MEM_W-1:0] wd;
            if ($urandom_range(0, 3) == 0) wr($urandom_range(0, NT - 1), $urandom);
            if ($urandom_range(0, 7) == 0) wr(NT, 32'($urandom_range(0, 1)));
            ch = $urandom_range(0, NC - 1);
            x  = int'($urandom_range(0, 16777215)) - 8388608;
            cw = ($urandom_range(0, 4) == 0);
            wa = $urandom_range(0, NT + 2);
            wd = $urandom;
            st = $urandom_range(0, 2);
            if (cw) model_write(wa, wd);
            model_sample(ch, x, mr, ms);
            xfer(ch, x, mr, ms, $sformatf("rand%0d", it), st, cw, wa, wd);
        end

        // Reset while a result is being held.
        setup(5);
        wr(NT, 32'h2);
        model_sample(3, 3000000, mr, ms);
        wait_ready("rstmid");
        out_ready = 1'b0;
        in_valid = 1'b1; in_ch = CH_W'(3); flt_in = IN_W'(3000000);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        chk("rstmid held data", longint'($signed(flt_out)), 1500000);
        rst = 1'b1;
        #1;
        chk("rstmid out_valid", longint'(out_valid), 0);
        chk("rstmid flt_out", longint'(flt_out), 0);
        chk("rstmid out_ch", longint'(out_ch), 0);
        chk("rstmid in_ready", longint'(in_ready), 0);
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("rstmid ready after release", longint'(in_ready), 1);
        chk("rstmid no stale output", longint'(out_valid), 0);
        model_reset();
        model_sample(0, 1000, mr, ms);
        xfer(0, 1000, mr, ms, "post-reset impulse", 0, 1'b0, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
